// File: rtl/add_tag_pkg.sv
// Shared types and helpers for the add_tag_queue tagging stage.
package add_tag_pkg;

  typedef enum logic {
    TAG_STATIC = 1'b0,
    TAG_SEQ    = 1'b1
  } tag_mode_e;

  localparam int unsigned SeqWMax = 16;

  // Wrap-around sequence step; callers zero-extend and truncate to their tag width.
  function automatic logic [SeqWMax-1:0] seq_next(input logic [SeqWMax-1:0] cur,
                                                  input logic [SeqWMax-1:0] limit);
    return (cur >= limit) ? '0 : cur + 16'd1;
  endfunction

endpackage

// File: rtl/add_tag_queue_if.sv
// Producer/consumer handshake bundle for add_tag_queue; slave is the stage side.
interface add_tag_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [TAG_W+DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/add_tag_seq.sv
// Auto-incrementing tag sequence; advances only on pushes made in sequence mode.
module add_tag_seq
  import add_tag_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  tag_mode_e        i_mode,
  input  logic [TAG_W-1:0] i_limit,
  output logic [TAG_W-1:0] o_tag
);

  logic [TAG_W-1:0] r_seq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (i_push && (i_mode == TAG_SEQ)) begin
      r_seq <= TAG_W'(seq_next(16'(r_seq), 16'(i_limit)));
    end
  end

  assign o_tag = r_seq;

endmodule

// File: rtl/add_tag_queue.sv
// Buffered tag-attachment stage: tags tokens on push, queues them in a circular buffer.
// Optional ADD_TAG_QUEUE_STATS_EN adds saturating pop and stall counters.
module add_tag_queue
  import add_tag_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  add_tag_queue_if.slave             bus,
  input  logic                       cfg_mode,
  input  logic [TAG_W-1:0]           cfg_tag,
  input  logic [TAG_W-1:0]           cfg_tag_limit,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef ADD_TAG_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_tokens,
  output logic [31:0]                stat_stalls
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = TAG_W + DATA_W;

  logic [EntW-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [OccW-1:0]  r_occ;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [TAG_W-1:0] w_seq_tag;
  logic [TAG_W-1:0] w_tag;
  tag_mode_e        w_mode;

  // Handshake flags come only from registered occupancy: no out_ready -> in_ready path.
  assign w_in_ready  = (r_occ != OccW'(DEPTH));
  assign w_out_valid = (r_occ != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_mode      = tag_mode_e'(cfg_mode);
  assign w_tag       = (w_mode == TAG_SEQ) ? w_seq_tag : cfg_tag;

  add_tag_seq #(
    .TAG_W (TAG_W)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_mode  (w_mode),
    .i_limit (cfg_tag_limit),
    .o_tag   (w_seq_tag)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_tag, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OccW'(1);
        2'b01:   r_occ <= r_occ - OccW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  // Empty queue presents zero so stale entries never leak after reset.
  assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign occupancy     = r_occ;

`ifdef ADD_TAG_QUEUE_STATS_EN
  logic [31:0] r_stat_tokens;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_tokens <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_pop && (r_stat_tokens != '1)) r_stat_tokens <= r_stat_tokens + 32'd1;
      if (w_out_valid && !bus.out_ready && (r_stat_stalls != '1)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_tokens = r_stat_tokens;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_add_tag_queue.sv
// Self-checking bench for add_tag_queue: queue-based reference model plus directed literal checks.
module tb_add_tag_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              cfg_mode;
  logic [TAG_W-1:0]  cfg_tag;
  logic [TAG_W-1:0]  cfg_tag_limit;
  logic [OCC_W-1:0]  occupancy;
`ifdef ADD_TAG_QUEUE_STATS_EN
  logic [31:0]       stat_tokens;
  logic [31:0]       stat_stalls;
  longint            m_tok;
  longint            m_stall;
`endif

  add_tag_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  add_tag_queue #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .cfg_mode      (cfg_mode),
    .cfg_tag       (cfg_tag),
    .cfg_tag_limit (cfg_tag_limit),
    .occupancy     (occupancy)
`ifdef ADD_TAG_QUEUE_STATS_EN
    ,
    .stat_tokens   (stat_tokens),
    .stat_stalls   (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {tag, data} plus the sequence value.
  logic [TAG_W+DATA_W-1:0] mq[$];
  int unsigned             m_seq;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      mq.delete();
      m_seq  = 0;
      chk_en = 1'b1;
`ifdef ADD_TAG_QUEUE_STATS_EN
      m_tok   = 0;
      m_stall = 0;
`endif
    end else begin
      do_pop  = (mq.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (mq.size() < DEPTH);
`ifdef ADD_TAG_QUEUE_STATS_EN
      if (do_pop && m_tok < 64'hFFFF_FFFF) m_tok++;
      if ((mq.size() != 0) && !bus.out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (cfg_mode) begin
          mq.push_back({TAG_W'(m_seq), bus.in_data});
          m_seq = (m_seq >= cfg_tag_limit) ? 0 : m_seq + 1;
        end else begin
          mq.push_back({cfg_tag, bus.in_data});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [TAG_W+DATA_W-1:0] exp_data;
    if (chk_en) begin
      exp_data = '0;
      if (mq.size() != 0) exp_data = mq[0];
      check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("in_ready",  64'(bus.in_ready),  64'(mq.size() != DEPTH));
      check("occupancy", 64'(occupancy),     64'(mq.size()));
      check("out_data",  64'(bus.out_data),  64'(exp_data));
`ifdef ADD_TAG_QUEUE_STATS_EN
      check("stat_tokens", 64'(stat_tokens), 64'(m_tok));
      check("stat_stalls", 64'(stat_stalls), 64'(m_stall));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [TAG_W-1:0]  exp_tags [5];
    logic [DATA_W-1:0] exp_drain [4];
    exp_tags  = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    exp_drain = '{32'd101, 32'd102, 32'd103, 32'd200};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    cfg_mode      = 1'b0;
    cfg_tag       = '0;
    cfg_tag_limit = '0;
    do_reset();

    // Reset state and static-tag single token.
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_out_data",  64'(bus.out_data), 64'd0);
    cfg_mode = 1'b0; cfg_tag = 4'hA;
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF; bus.out_ready = 1'b1;
    tick();
    check("static_valid", 64'(bus.out_valid), 64'd1);
    check("static_data",  64'(bus.out_data), 64'hA_DEAD_BEEF);
    bus.in_valid = 1'b0;
    tick();
    check("static_drained", 64'(occupancy), 64'd0);

    // Sequence wrap with limit 2.
    do_reset();
    cfg_mode = 1'b1; cfg_tag_limit = 4'd2; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 32'(i);
      tick();
      check("seq_tag", 64'(bus.out_data[TAG_W+DATA_W-1:DATA_W]), 64'(exp_tags[i]));
    end
    bus.in_valid = 1'b0;
    tick();

    // Fill and backpressure, then full with simultaneous pop.
    do_reset();
    cfg_mode = 1'b0; cfg_tag = 4'h5; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 32'(100 + i);
      tick();
      if (i == 3) begin
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_occ4", 64'(occupancy), 64'd4);
      end
    end
    check("fill_occ_hold", 64'(occupancy), 64'd4);
    bus.in_data = 32'd200; bus.out_ready = 1'b1;
    tick();
    check("fullpop_occ", 64'(occupancy), 64'd3);
    check("fullpop_head", 64'(bus.out_data), {4'h5, 32'd101});
    bus.out_ready = 1'b0;
    tick();
    check("fullpop_push", 64'(occupancy), 64'd4);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 64'(bus.out_data[DATA_W-1:0]), 64'(exp_drain[i]));
      tick();
    end
    check("drain_empty", 64'(occupancy), 64'd0);

    // Config change while queued.
    cfg_tag = 4'd3; bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678;
    tick();
    bus.in_valid = 1'b0; cfg_tag = 4'd7;
    tick();
    check("cfgchg_tag", 64'(bus.out_data), 64'h3_1234_5678);
    bus.out_ready = 1'b1;
    tick();

    // Mid-stream reset clears entries and sequence state.
    do_reset();
    cfg_mode = 1'b1; cfg_tag_limit = 4'hF; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'(i + 50);
      tick();
    end
    check("midrst_pre", 64'(occupancy), 64'd3);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_occ", 64'(occupancy), 64'd0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = 32'hCAFE_0001;
    tick();
    check("midrst_seq0", 64'(bus.out_data), 64'h0_CAFE_0001);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();

    // Randomized traffic with shifting bias, config churn and rare resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int unsigned vbias = (cyc / 500) % 4;
      bus.in_valid  = ($urandom_range(3) >= vbias);
      bus.out_ready = ($urandom_range(3) < ((cyc / 250) % 4) + 1);
      bus.in_data   = $urandom;
      if ($urandom_range(40) == 0) begin
        cfg_mode      = $urandom_range(1);
        cfg_tag       = TAG_W'($urandom);
        cfg_tag_limit = TAG_W'($urandom);
      end
      rst_n = ($urandom_range(300) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
